// File: rtl/stack_pkg.sv
// Shared encodings for the hardware stack command sequencer.
package stack_pkg;

  localparam int STACK_DEPTH = 128;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK  = 2'b00,
    ERR_OVF = 2'b01,
    ERR_UNF = 2'b10,
    ERR_TMO = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_ACK_WAIT,
    ST_DONE_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Saturating handshake-wait counter; o_expired flags the last allowed wait cycle.
module seq_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LP_LAST)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == LP_LAST);

endmodule

// File: rtl/stack_cmd_sequencer.sv
// Host command front end for the 128x8 stack: guards full/empty, drives the
// push/pop strobes, waits on stk_done with a timeout and returns a response.
//   state        | meaning
//   ST_IDLE      | ready for a host command
//   ST_CHECK     | evaluate op against full/empty, answer NOP/PEEK/rejects
//   ST_REQ       | first strobe cycle, timeout counter cleared
//   ST_ACK_WAIT  | strobe held until stack drops stk_done
//   ST_DONE_WAIT | wait for stk_done high, capture popped byte
//   ST_RESP      | response presented until rsp_ready
module stack_cmd_sequencer
  import stack_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_err,
  output logic       stk_push,
  output logic       stk_pop,
  output logic [7:0] stk_wdata,
  output logic       stk_wdata_oe,
  input  logic [7:0] stk_rdata,
  input  logic       stk_done,
  input  logic       stk_empty,
  input  logic       stk_full
);

  state_e     r_state;
  state_e     w_state_nxt;
  op_e        r_op;
  logic [7:0] r_data;
  logic [7:0] r_rsp_data;
  err_e       r_rsp_err;
  logic       r_cmd_ready;

  logic       w_accept;
  logic       w_is_push;
  logic       w_is_pop;
  logic       w_rsp_load;
  logic [7:0] w_rsp_data_nxt;
  err_e       w_rsp_err_nxt;
  logic       w_clr;
  logic       w_en;
  logic       w_expired;

  assign w_accept  = cmd_valid && r_cmd_ready;
  assign w_is_push = (r_op == OP_PUSH);
  assign w_is_pop  = (r_op == OP_POP);

  seq_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_rsp_load     = 1'b0;
    w_rsp_data_nxt = '0;
    w_rsp_err_nxt  = ERR_OK;
    w_clr          = 1'b0;
    w_en           = 1'b0;
    stk_push       = 1'b0;
    stk_pop        = 1'b0;
    stk_wdata_oe   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        w_state_nxt = ST_RESP;
        w_rsp_load  = 1'b1;
        case (r_op)
          OP_PUSH: begin
            if (stk_full) w_rsp_err_nxt = ERR_OVF;
            else begin
              w_rsp_load  = 1'b0;
              w_state_nxt = ST_REQ;
            end
          end
          OP_POP: begin
            if (stk_empty) w_rsp_err_nxt = ERR_UNF;
            else begin
              w_rsp_load  = 1'b0;
              w_state_nxt = ST_REQ;
            end
          end
          OP_PEEK: begin
            if (stk_empty) w_rsp_err_nxt = ERR_UNF;
            else w_rsp_data_nxt = stk_rdata;
          end
          default: ;
        endcase
      end
      ST_REQ: begin
        stk_push     = w_is_push;
        stk_pop      = w_is_pop;
        stk_wdata_oe = w_is_push;
        w_clr        = 1'b1;
        w_state_nxt  = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        w_en = 1'b1;
        // On the timeout cycle the strobe is already released so the stack
        // cannot start an operation whose response was abandoned.
        if (!stk_done) begin
          stk_push     = w_is_push;
          stk_pop      = w_is_pop;
          stk_wdata_oe = w_is_push;
          w_clr        = 1'b1;
          w_state_nxt  = ST_DONE_WAIT;
        end else if (w_expired) begin
          w_rsp_load    = 1'b1;
          w_rsp_err_nxt = ERR_TMO;
          w_state_nxt   = ST_RESP;
        end else begin
          stk_push     = w_is_push;
          stk_pop      = w_is_pop;
          stk_wdata_oe = w_is_push;
        end
      end
      ST_DONE_WAIT: begin
        w_en = 1'b1;
        if (stk_done) begin
          stk_wdata_oe = w_is_push;
          w_rsp_load   = 1'b1;
          if (w_is_pop) w_rsp_data_nxt = stk_rdata;
          w_state_nxt  = ST_RESP;
        end else if (w_expired) begin
          w_rsp_load    = 1'b1;
          w_rsp_err_nxt = ERR_TMO;
          w_state_nxt   = ST_RESP;
        end else begin
          stk_wdata_oe = w_is_push;
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_op        <= OP_NOP;
      r_data      <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= ERR_OK;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_op   <= op_e'(cmd_op);
        r_data <= cmd_data;
      end
      if (w_rsp_load) begin
        r_rsp_data <= w_rsp_data_nxt;
        r_rsp_err  <= w_rsp_err_nxt;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign stk_wdata = stk_wdata_oe ? r_data : 8'h00;

endmodule

// File: doc/stack_cmd_sequencer.md
Name: stack_cmd_sequencer

Overview:
- Upstream front end for the 128x8 hardware stack.
- Accepts byte-wide host commands (PUSH/POP/PEEK/NOP) over a valid/ready channel and translates them into the stack's push/pop level strobes and data-bus drive.
- Waits for the stack's instruction-done handshake, with a timeout, then returns data and status on a valid/ready response channel.
- Guards overflow and underflow using the stack's full/empty flags, so illegal operations never reach the stack.

Parameters:
TIMEOUT_CYCLES, 16, max cycles to wait in either stack handshake phase before aborting (range 2..255)
CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_op  in  2  00 NOP, 01 PUSH, 10 POP, 11 PEEK
cmd_data  in  8  push operand
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_data  out  8  popped/peeked byte; 0 for PUSH/NOP/error
rsp_err  out  2  00 ok, 01 overflow, 10 underflow, 11 timeout
stk_push  out  1  push request level to stack
stk_pop  out  1  pop request level to stack
stk_wdata  out  8  data driven onto stack bus
stk_wdata_oe  out  1  high while stk_wdata is being driven (PUSH only)
stk_rdata  in  8  stack top-of-stack read data
stk_done  in  1  stack idle/instruction-done level
stk_empty  in  1  stack pointer == 0
stk_full  in  1  stack pointer == 127

Behaviour:
- Reset (async, rst_n low): state IDLE; cmd_ready=0 during reset, 1 on the first clock after release; rsp_valid=0, rsp_data=0, rsp_err=00, stk_push=0, stk_pop=0, stk_wdata=0, stk_wdata_oe=0, timeout count=0.
- Reset asserted mid-operation aborts immediately; no response is produced for the aborted command.
- FSM states: IDLE, CHECK, REQ, ACK_WAIT, DONE_WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/data and go to CHECK.
- CHECK (1 cycle):
  - NOP: RESP with err 00.
  - PUSH with stk_full=1: RESP with err 01.
  - POP with stk_empty=1: RESP with err 10.
  - PEEK with stk_empty=1: RESP with err 10.
  - PEEK otherwise: RESP with rsp_data=stk_rdata sampled this cycle, err 00.
  - PUSH/POP otherwise: REQ.
- REQ (1 cycle): assert stk_push or stk_pop. For PUSH, stk_wdata=latched data and stk_wdata_oe=1. Clear the counter and go to ACK_WAIT.
- ACK_WAIT: hold the strobe and data until stk_done is sampled low, then drop the strobe and go to DONE_WAIT. stk_wdata_oe stays high until DONE_WAIT exits.
- DONE_WAIT: wait for stk_done high. For POP, capture rsp_data from stk_rdata in the same cycle stk_done is seen high. Then go to RESP with err 00.
- Timeout: in ACK_WAIT or DONE_WAIT, the counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 without the awaited edge:
  - drop all strobes and oe;
  - go to RESP with err 11 and rsp_data=0.
- RESP: rsp_valid=1, holding data and err stable until rsp_ready. On the handshake cycle go to IDLE; rsp_valid drops on the next cycle.
- Ordering rules:
  - Strict one-command-in-flight; no command is accepted while rsp_valid=1.
  - stk_push and stk_pop are never both high.
- Latency (stack acks in 1 cycle, done 2 cycles later): accept→rsp_valid = 5 cycles for PUSH/POP. Guard-rejected or PEEK: 2 cycles.
- Counter saturates; it does not wrap.

Decomposition:
- Shared package stack_pkg:
  - op encodings: OP_NOP, OP_PUSH, OP_POP, OP_PEEK;
  - error encodings: ERR_OK, ERR_OVF, ERR_UNF, ERR_TMO;
  - FSM state enum;
  - STACK_DEPTH=128.
- One sub-module is natural: seq_timeout_ctr (clear, enable, expired output; parameterised by TIMEOUT_CYCLES and CNT_W).

Test Plan:
- Reset mid-ACK_WAIT: issue PUSH 0x5A, pull rst_n low while stk_push=1 → all outputs 0 asynchronously; after release cmd_ready=1 and no rsp_valid.
- PUSH 0x3C with model stack (ack 1 cycle, done 2 cycles later) → stk_wdata=0x3C with oe=1 through the handshake; rsp_valid 5 cycles after accept; err 00; model holds 0x3C.
- POP after pushes 0x11,0x22 → rsp_data=0x22 err 00; second POP → 0x11; third POP with stk_empty=1 → err 10, stk_pop never asserted.
- PUSH with stk_full=1 → err 01 within 2 cycles, stk_push never asserted.
- PEEK with top=0x77 → rsp_data=0x77, err 00, stack pointer unchanged, no strobe.
- Stack never drops stk_done, TIMEOUT_CYCLES=16 → stk_pop released after 16 cycles, rsp_err 11, rsp_data 0. Hold rsp_ready=0 for 10 cycles → response stays stable and cmd_ready stays 0.
